shiftq_max: RTL and testbench

- Sorted shift-register priority queue holding up to D unsigned keys.
- The largest key is always at the head.
- Each slot has its own unsigned greater-than compare against the incoming key, so insertion completes in one cycle.
- Sits between the producer and consumer stages of the queue subsystem: the producer enqueues, the consumer dequeues the current maximum.

---
 rtl/shiftq_max.sv | 103 ++++++++++
 tb/tb_shiftq_max.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/shiftq_max.sv
// Sorted shift-register max priority queue: head slot 0 always holds the largest key.
// Optional sticky error flag for dropped requests is enabled by defining SHIFTQ_ERR_EN.
module shiftq_max #(
  parameter int unsigned W = 8,
  parameter int unsigned D = 8,
  localparam int unsigned CW = $clog2(D + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enq,
  input  logic [W-1:0]  kin,
  input  logic          deq,
  output logic [W-1:0]  kout,
  output logic          empty,
  output logic          full,
`ifdef SHIFTQ_ERR_EN
  output logic          err,
`endif
  output logic [CW-1:0] count
);

  logic [W-1:0]  s_q [D];
  logic [W-1:0]  s_d [D];
  logic [D-1:0]  v_q, v_d;
  logic [CW-1:0] count_q, count_d;
  logic [W-1:0]  kout_q;
  logic          empty_q, full_q;

  logic [W-1:0]  base_s [D];
  logic [D-1:0]  base_v;
  logic [D-1:0]  gt;
  logic          deq_eff, enq_eff;

  always_comb begin
    deq_eff = deq && v_q[0];
    // With a simultaneous dequeue, a full queue frees a slot before insertion.
    enq_eff = enq && (!v_q[D-1] || deq_eff);

    for (int i = 0; i < int'(D) - 1; i++) begin
      base_s[i] = deq_eff ? s_q[i+1] : s_q[i];
      base_v[i] = deq_eff ? v_q[i+1] : v_q[i];
    end
    base_s[D-1] = deq_eff ? '0 : s_q[D-1];
    base_v[D-1] = deq_eff ? 1'b0 : v_q[D-1];

    // Sorted order makes gt a thermometer code; its first set bit is the insertion slot.
    // Strict compare places a new key after equal keys already queued.
    for (int i = 0; i < int'(D); i++) begin
      gt[i] = !base_v[i] || (kin > base_s[i]);
    end

    s_d[0] = (enq_eff && gt[0]) ? kin : base_s[0];
    v_d[0] = enq_eff ? 1'b1 : base_v[0];
    for (int i = 1; i < int'(D); i++) begin
      s_d[i] = base_s[i];
      v_d[i] = base_v[i];
      if (enq_eff && gt[i]) begin
        s_d[i] = gt[i-1] ? base_s[i-1] : kin;
        v_d[i] = gt[i-1] ? base_v[i-1] : 1'b1;
      end
    end

    count_d = count_q + CW'(enq_eff) - CW'(deq_eff);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q     <= '{default: '0};
      v_q     <= '0;
      count_q <= '0;
      kout_q  <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      s_q     <= s_d;
      v_q     <= v_d;
      count_q <= count_d;
      kout_q  <= v_d[0] ? s_d[0] : '0;
      empty_q <= (count_d == '0);
      full_q  <= (count_d == CW'(D));
    end
  end

`ifdef SHIFTQ_ERR_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if ((enq && !deq && v_q[D-1]) || (deq && !enq && !v_q[0])) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`endif

  assign kout  = kout_q;
  assign empty = empty_q;
  assign full  = full_q;
  assign count = count_q;

endmodule

// File: tb/tb_shiftq_max.sv
// Bench for shiftq_max: directed scenarios plus random traffic against a sorted-queue model.
module tb_shiftq_max;

  localparam int unsigned W  = 8;
  localparam int unsigned D  = 8;
  localparam int unsigned CW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enq = 1'b0;
  logic          deq = 1'b0;
  logic [W-1:0]  kin = '0;
  logic [W-1:0]  kout;
  logic          empty, full;
  logic [CW-1:0] count;
`ifdef SHIFTQ_ERR_EN
  logic          err;
`endif

  shiftq_max #(.W(W), .D(D)) dut (
    .clk   (clk),
    .rst   (rst),
    .enq   (enq),
    .kin   (kin),
    .deq   (deq),
    .kout  (kout),
    .empty (empty),
    .full  (full),
`ifdef SHIFTQ_ERR_EN
    .err   (err),
`endif
    .count (count)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [W-1:0] mq[$];
  logic         m_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: descending list, new key goes before the first strictly smaller key.
  task automatic model_step(input logic r, input logic e, input logic d, input logic [W-1:0] k);
    int sz;
    int idx;
    logic did_deq;
    if (r) begin
      mq.delete();
      m_err = 1'b0;
      return;
    end
    sz = mq.size();
    if ((e && !d && sz == int'(D)) || (d && !e && sz == 0)) m_err = 1'b1;
    did_deq = d && (sz > 0);
    if (did_deq) void'(mq.pop_front());
    if (e && (sz < int'(D) || did_deq)) begin
      idx = mq.size();
      for (int i = 0; i < mq.size(); i++) begin
        if (mq[i] < k) begin
          idx = i;
          break;
        end
      end
      mq.insert(idx, k);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".kout"},  32'(kout),  (mq.size() > 0) ? 32'(mq[0]) : 32'd0);
    check({tag, ".count"}, 32'(count), 32'(mq.size()));
    check({tag, ".empty"}, 32'(empty), 32'(mq.size() == 0));
    check({tag, ".full"},  32'(full),  32'(mq.size() == int'(D)));
`ifdef SHIFTQ_ERR_EN
    check({tag, ".err"},   32'(err),   32'(m_err));
`endif
  endtask

  task automatic step(input logic r, input logic e, input logic d, input logic [W-1:0] k,
                      input string tag);
    rst = r; enq = e; deq = d; kin = k;
    @(posedge clk);
    model_step(r, e, d, k);
    #1;
    check_all(tag);
  endtask

  initial begin
    m_err = 1'b0;
    step(1'b1, 1'b0, 1'b0, 8'h00, "rst");
    step(1'b0, 1'b0, 1'b0, 8'h00, "idle");
    step(1'b1, 1'b1, 1'b0, 8'h55, "rst_enq");
    check("rst_enq.kout0", 32'(kout), 32'd0);

    // Ties keep arrival order; dequeues drain in descending order.
    step(1'b0, 1'b1, 1'b0, 8'h10, "e10");
    check("latency.kout", 32'(kout), 32'h10);
    step(1'b0, 1'b1, 1'b0, 8'h40, "e40");
    step(1'b0, 1'b1, 1'b0, 8'h20, "e20");
    step(1'b0, 1'b1, 1'b0, 8'h40, "e40b");
    check("four.count", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 8'h00, "drain");
    check("drained.empty", 32'(empty), 32'd1);

    // Full queue: plain enqueue is dropped, enqueue with dequeue replaces head.
    for (int i = 1; i <= 8; i++) step(1'b0, 1'b1, 1'b0, 8'(i), "fill");
    step(1'b0, 1'b1, 1'b0, 8'hFF, "full_drop");
    check("full_drop.kout", 32'(kout), 32'h08);
    step(1'b0, 1'b1, 1'b1, 8'hFF, "full_swap");
    check("full_swap.kout", 32'(kout), 32'hFF);
    check("full_swap.count", 32'(count), 32'd8);

    step(1'b1, 1'b0, 1'b0, 8'h00, "rst2");
    step(1'b0, 1'b1, 1'b0, 8'd30, "e30");
    step(1'b0, 1'b1, 1'b0, 8'd20, "e20");
    step(1'b0, 1'b1, 1'b0, 8'd10, "e10");
    step(1'b0, 1'b1, 1'b1, 8'd25, "swap25");
    check("swap25.kout", 32'(kout), 32'd25);
    step(1'b0, 1'b1, 1'b1, 8'd5, "swap5");
    check("swap5.kout", 32'(kout), 32'd20);
    check("swap5.count", 32'(count), 32'd3);

    step(1'b1, 1'b0, 1'b0, 8'h00, "rst3");
    step(1'b0, 1'b0, 1'b1, 8'h00, "deq_empty");
    step(1'b0, 1'b1, 1'b1, 8'h07, "ed_empty");
    check("ed_empty.kout", 32'(kout), 32'h07);
    check("ed_empty.count", 32'(count), 32'd1);

    // Random traffic: phases bias towards filling or draining; small keys force ties.
    for (int c = 0; c < 10000; c++) begin
      int unsigned ep;
      logic r, e, d;
      logic [W-1:0] k;
      ep = ((c / 500) % 2 == 0) ? 65 : 35;
      r  = ($urandom_range(0, 299) == 0);
      e  = ($urandom_range(0, 99) < ep);
      d  = ($urandom_range(0, 99) < 50);
      k  = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
      step(r, e, d, k, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
